// File: rtl/convert_results_datapath_pkg.sv
// Shared definitions for the float-to-packed-decimal result converter:
// packed-word field positions, float constants and the FSM state type.
package convert_results_datapath_pkg;

  localparam int CNT_W = 5;

  localparam int SAT_BIT   = 22;
  localparam int VSIGN_BIT = 20;
  localparam int ESIGN_BIT = 19;
  localparam int E_LSB     = 10;
  localparam int E_W       = 9;
  localparam int M_W       = 10;

  localparam logic [E_W-1:0] E_MAX = '1;
  localparam logic [M_W-1:0] M_MAX = '1;

  localparam logic [31:0] F_ONE     = 32'h3F80_0000;
  localparam logic [31:0] F_TEN     = 32'h4120_0000;
  localparam logic [31:0] F_TENTH   = 32'h3DCC_CCCD;
  localparam logic [31:0] F_HUNDRED = 32'h42C8_0000;
  localparam logic [31:0] F_K1024   = 32'h4480_0000;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_CHECK, S_MULT, S_CONVERT, S_WRITE, S_DONE
  } state_t;

  function automatic logic [31:0] pack_word(input logic sat, input logic vsign,
                                            input logic esign, input logic [E_W-1:0] e,
                                            input logic [M_W-1:0] m);
    logic [31:0] w;
    w                = '0;
    w[SAT_BIT]       = sat;
    w[VSIGN_BIT]     = vsign;
    w[ESIGN_BIT]     = esign;
    w[E_LSB +: E_W]  = e;
    w[M_W-1:0]       = m;
    return w;
  endfunction

endpackage

// File: rtl/convert_results_datapath_latency_countdown.sv
// Reloadable down-counter; expired is high once the loaded latency has elapsed.
module latency_countdown
  import convert_results_datapath_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [CNT_W-1:0] lat,
  output logic             expired
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!resetn)         cnt <= '0;
    else if (load)       cnt <= lat - CNT_W'(1);
    else if (cnt != '0)  cnt <= cnt - CNT_W'(1);
  end

  // A lat of N keeps the owning state for exactly N cycles.
  assign expired = (cnt == '0) && !load;

endmodule

// File: rtl/convert_results_datapath.sv
// Converts IEEE-754 singles from float_register into packed m*10^e words,
// scaling by 10 / 0.1 on the shared multiplier until 100 <= x < 1024.
module convert_results_datapath
  import convert_results_datapath_pkg::*;
#(
  parameter int RD_LAT   = 2,
  parameter int MULT_LAT = 11,
  parameter int CONV_LAT = 6
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [4:0]  numValues,
  output logic        busy,
  output logic        done,
  output logic [4:0]  float_register_addr,
  input  logic [31:0] float_register_q,
  output logic [4:0]  result_addr,
  output logic [31:0] result_data,
  output logic        result_wren,
  output logic [31:0] multiplier_data_a,
  output logic [31:0] multiplier_data_b,
  input  logic [31:0] multiplier_out,
  output logic [31:0] fp_to_int_data,
  input  logic [31:0] fp_to_int_out
);

  state_t           state, next;
  logic [4:0]       addr, num, addr_inc;
  logic [31:0]      x;
  logic             vsign, esign, sat;
  logic [E_W-1:0]   e;
  logic [M_W-1:0]   m;
  logic             cnt_load, expired;
  logic [CNT_W-1:0] cnt_lat;
  logic             exp_special, exp_zero, too_big, too_small, scale;
  logic             unused_conv_hi;

  assign unused_conv_hi = ^fp_to_int_out[31:M_W];

  assign exp_special = (x[30:23] == 8'hFF);
  assign exp_zero    = (x[30:23] == 8'h00);
  // x has its sign bit cleared, so unsigned compares order the floats.
  assign too_big     = (x >= F_K1024);
  assign too_small   = (x <  F_HUNDRED);
  assign scale       = too_big || too_small;
  assign addr_inc    = addr + 5'd1;

  latency_countdown u_cd (
    .clk     (clk),
    .resetn  (resetn),
    .load    (cnt_load),
    .lat     (cnt_lat),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= next;
  end

  always_comb begin
    next     = state;
    cnt_load = 1'b0;
    cnt_lat  = CNT_W'(RD_LAT);
    case (state)
      S_IDLE:
        if (start) begin
          if (numValues == '0) next = S_DONE;
          else begin
            next     = S_FETCH;
            cnt_load = 1'b1;
          end
        end
      S_FETCH:   if (expired) next = S_CHECK;
      S_CHECK:
        if (exp_special || exp_zero) next = S_WRITE;
        else if (scale && e != E_MAX) begin
          next     = S_MULT;
          cnt_load = 1'b1;
          cnt_lat  = CNT_W'(MULT_LAT);
        end else begin
          next     = S_CONVERT;
          cnt_load = 1'b1;
          cnt_lat  = CNT_W'(CONV_LAT);
        end
      S_MULT:    if (expired) next = S_CHECK;
      S_CONVERT: if (expired) next = S_WRITE;
      S_WRITE:
        if (addr_inc == num) next = S_DONE;
        else begin
          next     = S_FETCH;
          cnt_load = 1'b1;
        end
      S_DONE:    next = S_IDLE;
      default:   next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      addr              <= '0;
      num               <= '0;
      x                 <= '0;
      vsign             <= 1'b0;
      esign             <= 1'b0;
      sat               <= 1'b0;
      e                 <= '0;
      m                 <= '0;
      multiplier_data_a <= '0;
      multiplier_data_b <= '0;
      fp_to_int_data    <= '0;
    end else begin
      case (state)
        S_IDLE:
          if (start) begin
            num  <= numValues;
            addr <= '0;
          end
        S_FETCH:
          if (expired) begin
            vsign <= float_register_q[31];
            x     <= {1'b0, float_register_q[30:0]};
            e     <= '0;
            esign <= 1'b0;
            sat   <= 1'b0;
            m     <= '0;
          end
        S_CHECK: begin
          if (exp_special) begin
            sat   <= 1'b1;
            e     <= E_MAX;
            esign <= 1'b0;
            m     <= M_MAX;
          end else if (exp_zero) begin
            vsign <= 1'b0;
            m     <= '0;
          end else if (scale && e == E_MAX) begin
            sat <= 1'b1;
          end else if (scale) begin
            e                 <= e + E_W'(1);
            esign             <= too_small;
            multiplier_data_a <= x;
            multiplier_data_b <= too_big ? F_TENTH : F_TEN;
          end
          if (next == S_CONVERT) fp_to_int_data <= x;
        end
        S_MULT:    if (expired) x <= multiplier_out;
        S_CONVERT: if (expired) m <= fp_to_int_out[M_W-1:0];
        S_WRITE:   addr <= addr_inc;
        default: ;
      endcase
    end
  end

  assign busy                = (state != S_IDLE) && (state != S_DONE);
  assign done                = (state == S_DONE);
  assign result_wren         = (state == S_WRITE);
  assign result_addr         = addr;
  assign float_register_addr = addr;
  assign result_data         = pack_word(sat, vsign, esign, e, m);

endmodule

// File: tb/tb_convert_results_datapath.sv
// Bench for convert_results_datapath: behavioural RAM, multiplier and
// float-to-int models plus a write scoreboard.
module tb_convert_results_datapath;

  localparam int RD_LAT   = 2;
  localparam int MULT_LAT = 11;
  localparam int CONV_LAT = 6;

  logic        clk = 1'b0;
  logic        resetn, start, busy, done, result_wren;
  logic [4:0]  numValues, float_register_addr, result_addr;
  logic [31:0] float_register_q, result_data;
  logic [31:0] multiplier_data_a, multiplier_data_b, multiplier_out;
  logic [31:0] fp_to_int_data, fp_to_int_out;

  always #5 clk = ~clk;

  convert_results_datapath #(.RD_LAT(RD_LAT), .MULT_LAT(MULT_LAT), .CONV_LAT(CONV_LAT)) dut (
    .clk(clk), .resetn(resetn), .start(start), .numValues(numValues),
    .busy(busy), .done(done),
    .float_register_addr(float_register_addr), .float_register_q(float_register_q),
    .result_addr(result_addr), .result_data(result_data), .result_wren(result_wren),
    .multiplier_data_a(multiplier_data_a), .multiplier_data_b(multiplier_data_b),
    .multiplier_out(multiplier_out),
    .fp_to_int_data(fp_to_int_data), .fp_to_int_out(fp_to_int_out)
  );

  // ---------------- float helpers (via double precision) ----------------
  function automatic real s2r(input logic [31:0] f);
    logic [63:0] d;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    logic [30:0] mag;
    logic [28:0] rem;
    d   = $realtobits(r);
    mag = {8'(d[62:52] - 11'd896), d[51:29]};
    rem = d[28:0];
    if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && mag[0])) mag = mag + 31'd1;
    return {d[63], mag};
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return 32'd0;
    return r2s(s2r(a) * s2r(b));
  endfunction

  function automatic logic [31:0] ftrunc(input logic [31:0] a);
    int          sh;
    logic [31:0] mant;
    if (a[30:23] < 8'd127) return 32'd0;
    sh   = int'(a[30:23]) - 127;
    mant = {8'd0, 1'b1, a[22:0]};
    if (sh <= 23) return mant >> (23 - sh);
    if (sh <= 30) return mant << (sh - 23);
    return 32'h7FFF_FFFF;
  endfunction

  // Reference conversion of one float into the packed decimal word.
  function automatic logic [31:0] ref_conv(input logic [31:0] q);
    logic [31:0] xr, mi;
    logic [8:0]  er;
    logic        vs, es, st;
    vs = q[31]; xr = {1'b0, q[30:0]}; er = 9'd0; es = 1'b0; st = 1'b0;
    if (xr[30:23] == 8'hFF) return {9'd0, 1'b1, 1'b0, vs, 1'b0, 9'h1FF, 10'h3FF};
    if (xr[30:23] == 8'h00) return 32'd0;
    for (int it = 0; it < 600; it++) begin
      if (xr >= 32'h4480_0000 || xr < 32'h42C8_0000) begin
        if (er == 9'h1FF) begin st = 1'b1; break; end
        er = er + 9'd1;
        es = (xr < 32'h42C8_0000);
        xr = fmul(xr, es ? 32'h4120_0000 : 32'h3DCC_CCCD);
      end else break;
    end
    mi = ftrunc(xr);
    return {9'd0, st, 1'b0, vs, es, er, mi[9:0]};
  endfunction

  // ---------------- environment models ----------------
  logic [31:0] mem [32];
  logic [31:0] mpipe [MULT_LAT-1];
  logic [31:0] cpipe [CONV_LAT-1];

  always @(posedge clk) float_register_q <= mem[float_register_addr];

  always @(posedge clk) begin
    mpipe[0] <= fmul(multiplier_data_a, multiplier_data_b);
    for (int i = 1; i < MULT_LAT-1; i++) mpipe[i] <= mpipe[i-1];
    cpipe[0] <= ftrunc(fp_to_int_data);
    for (int i = 1; i < CONV_LAT-1; i++) cpipe[i] <= cpipe[i-1];
  end
  assign multiplier_out = mpipe[MULT_LAT-2];
  assign fp_to_int_out  = cpipe[CONV_LAT-2];

  // ---------------- scoreboard / checking ----------------
  typedef struct packed { logic [4:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic [31:0] q; logic [31:0] exp; } vec_t;

  wr_t  sb[$];
  vec_t tbl[13];
  int   nvec = 0, errs = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input int a, input logic [31:0] d);
    wr_t w;
    w.addr = 5'(a);
    w.data = d;
    sb.push_back(w);
  endtask

  task automatic pop_check();
    wr_t w;
    if (sb.size() == 0) check("unexpected_write", 32'(result_addr), 32'hFFFF_FFFF);
    else begin
      w = sb.pop_front();
      check("write_addr", 32'(result_addr), 32'(w.addr));
      check("write_data", result_data, w.data);
    end
  endtask

  // Start a run, compare every write against the scoreboard, stop at done.
  task automatic run(input int n, input int inject_at, input bit start_on_done,
                     output int wr_lat, output int done_lat, output int nwr);
    int cyc, extra;
    @(negedge clk); numValues = 5'(n); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0; wr_lat = -1; done_lat = -1; nwr = 0;
    while (cyc < 20000 && done_lat < 0) begin
      start = (cyc == inject_at);
      if (cyc == 0 && n > 0) check("busy_after_start", 32'(busy), 32'd1);
      if (result_wren) begin
        nwr++;
        if (wr_lat < 0) wr_lat = cyc;
        pop_check();
      end
      if (done) begin
        done_lat = cyc;
        if (start_on_done) start = 1'b1;
      end
      @(negedge clk); cyc++;
    end
    start = 1'b0;
    if (done_lat < 0) check("done_timeout", 32'd0, 32'd1);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    sb.delete();
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      if (result_wren || busy || done) extra++;
      @(negedge clk);
    end
    check("quiet_after_done", 32'(extra), 32'd0);
  endtask

  initial begin
    int wl, dl, nw, cyc, c;
    logic [31:0] a0, f0, q;

    tbl[0]  = '{32'h3F80_0000, 32'h0008_0864};  // 1.0
    tbl[1]  = '{32'h451C_4000, 32'h0000_04FA};  // 2500.0
    tbl[2]  = '{32'hC0A0_0000, 32'h0018_09F4};  // -5.0
    tbl[3]  = '{32'h0000_0000, 32'h0000_0000};  // +0
    tbl[4]  = '{32'h8000_0000, 32'h0000_0000};  // -0
    tbl[5]  = '{32'h7FC0_0000, 32'h0047_FFFF};  // NaN
    tbl[6]  = '{32'hFF80_0000, 32'h0057_FFFF};  // -Inf
    tbl[7]  = '{32'h42C8_0000, 32'h0000_0064};  // 100.0, no scaling
    tbl[8]  = '{32'h447F_C000, 32'h0000_03FF};  // 1023.0
    tbl[9]  = '{32'h4480_0000, 32'h0000_0466};  // 1024.0
    tbl[10] = '{32'h0000_0001, 32'h0000_0000};  // denormal
    tbl[11] = '{32'h3F00_0000, 32'h0008_0DF4};  // 0.5
    tbl[12] = '{32'h42C7_0000, 32'h0008_07E3};  // 99.5

    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    resetn = 1'b0; start = 1'b0; numValues = 5'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wren", 32'(result_wren), 32'd0);
    check("rst_faddr", 32'(float_register_addr), 32'd0);
    check("rst_raddr", 32'(result_addr), 32'd0);
    check("rst_rdata", result_data, 32'd0);
    check("rst_mult_a", multiplier_data_a, 32'd0);
    check("rst_mult_b", multiplier_data_b, 32'd0);
    check("rst_conv", fp_to_int_data, 32'd0);
    resetn = 1'b1;

    // 1.0 alone: two x10 iterations, latency 2+3+22+6 to the write cycle
    mem[0] = 32'h3F80_0000; push(0, 32'h0008_0864);
    run(1, -1, 1'b0, wl, dl, nw);
    check("one_wr_lat", 32'(wl), 32'd33);
    check("one_done_lat", 32'(dl), 32'd34);
    check("one_nwr", 32'(nw), 32'd1);

    // table run over all vectors in one pass
    for (int i = 0; i < 13; i++) begin
      mem[i] = tbl[i].q;
      push(i, tbl[i].exp);
    end
    run(13, -1, 1'b0, wl, dl, nw);
    check("tbl_nwr", 32'(nw), 32'd13);

    // -0.0 alone: fast path, no multiplier/converter traffic
    mem[0] = 32'h8000_0000; push(0, 32'd0);
    a0 = multiplier_data_a; f0 = fp_to_int_data;
    run(1, -1, 1'b0, wl, dl, nw);
    check("zero_wr_lat", 32'(wl), 32'd3);
    check("zero_mult_idle", multiplier_data_a, a0);
    check("zero_conv_idle", fp_to_int_data, f0);

    // numValues == 0
    run(0, -1, 1'b0, wl, dl, nw);
    check("n0_done_fast", 32'(dl >= 0 && dl <= 1), 32'd1);
    check("n0_nwr", 32'(nw), 32'd0);

    // 31 mixed values, extra start while busy and on the done cycle
    for (int i = 0; i < 31; i++) begin
      case ($urandom_range(0, 9))
        0:       q = 32'd0;
        1:       q = 32'h7FC0_0000;
        default: q = {1'($urandom), 8'($urandom_range(105, 150)), 23'($urandom)};
      endcase
      mem[i] = q;
      push(i, ref_conv(q));
    end
    run(31, 20, 1'b1, wl, dl, nw);
    check("mix_nwr", 32'(nw), 32'd31);

    // reset during MULT of the third value
    mem[0] = 32'h42C8_0000; mem[1] = 32'h42C8_0000; mem[2] = 32'h3F80_0000;
    push(0, 32'h64); push(1, 32'h64);
    @(negedge clk); numValues = 5'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0; nw = 0; c = -1;
    while (cyc < 2000 && !(c >= 0 && cyc == c + 8)) begin
      if (result_wren) begin
        nw++;
        pop_check();
        if (nw == 2) c = cyc;
      end
      @(negedge clk); cyc++;
    end
    check("rst_mid_reached", 32'(c >= 0), 32'd1);
    check("mid_mult_a", multiplier_data_a, 32'h3F80_0000);
    check("mid_mult_b", multiplier_data_b, 32'h4120_0000);
    resetn = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_wren", 32'(result_wren), 32'd0);
    check("abort_rdata", result_data, 32'd0);
    check("abort_mult_a", multiplier_data_a, 32'd0);
    check("abort_faddr", 32'(float_register_addr), 32'd0);
    resetn = 1'b1;
    sb.delete();
    c = 0;
    for (int i = 0; i < 60; i++) begin
      if (result_wren || done || busy) c++;
      @(negedge clk);
    end
    check("abort_quiet", 32'(c), 32'd0);

    // restart from address 0
    mem[0] = 32'h451C_4000; mem[1] = 32'hC0A0_0000;
    push(0, 32'h0000_04FA); push(1, 32'h0018_09F4);
    run(2, -1, 1'b0, wl, dl, nw);
    check("restart_nwr", 32'(nw), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end

endmodule
